// File: rtl/seat_debounce.sv
// Per-seat sync + debounce conditioner feeding the seat counter's occupancy input.
// Latency: raw edge captured at E0 appears on all outputs at E0+DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running, one sample per clock, all outputs registered.
module seat_debounce #(
    parameter int N_SEATS         = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1,
    localparam int COUNT_W = $clog2(N_SEATS + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_SEATS-1:0] i_seat_raw,
    output logic [N_SEATS-1:0] o_seat,
    output logic [N_SEATS-1:0] o_occupy,
    output logic [N_SEATS-1:0] o_vacate,
    output logic               o_change,
    output logic [COUNT_W-1:0] o_count
);

    // Terminal count: this many consecutive disagreeing samples flips the seat.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SEATS-1:0] sync1;
    logic [N_SEATS-1:0] s;
    logic [CNT_W-1:0]   cnt     [N_SEATS];
    logic [CNT_W-1:0]   cnt_nxt [N_SEATS];
    logic [N_SEATS-1:0] seat_nxt;
    logic [N_SEATS-1:0] occupy_nxt;
    logic [N_SEATS-1:0] vacate_nxt;
    logic [COUNT_W-1:0] count_nxt;

    // Two-flop synchroniser per seat; raw contacts are asynchronous to i_clk.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= i_seat_raw;
            s     <= sync1;
        end
    end

    // Per-seat debounce decision: a matching sample returns the seat to STABLE,
    // a run of DEBOUNCE_CYCLES disagreeing samples flips it and raises an event.
    always_comb begin
        seat_nxt   = o_seat;
        occupy_nxt = '0;
        vacate_nxt = '0;
        count_nxt  = '0;
        for (int k = 0; k < N_SEATS; k++) begin
            cnt_nxt[k] = '0;
            if (s[k] == o_seat[k]) begin
                cnt_nxt[k] = '0;
            end else if (cnt[k] == CNT_LAST) begin
                seat_nxt[k]   = s[k];
                occupy_nxt[k] = s[k];
                vacate_nxt[k] = ~s[k];
                cnt_nxt[k]    = '0;
            end else begin
                cnt_nxt[k] = cnt[k] + CNT_W'(1);
            end
        end
        // Count is taken from the next occupancy so it moves on the same edge.
        for (int k = 0; k < N_SEATS; k++) begin
            count_nxt = count_nxt + COUNT_W'(seat_nxt[k]);
        end
    end

    // Debounce counters; cleared by reset even in the middle of a pending flip.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < N_SEATS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_SEATS; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
        end
    end

    // Registered occupancy, single-cycle event pulses, change flag and count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_seat   <= '0;
            o_occupy <= '0;
            o_vacate <= '0;
            o_change <= 1'b0;
            o_count  <= '0;
        end else begin
            o_seat   <= seat_nxt;
            o_occupy <= occupy_nxt;
            o_vacate <= vacate_nxt;
            o_change <= |(occupy_nxt | vacate_nxt);
            o_count  <= count_nxt;
        end
    end

endmodule

// File: tb/tb_seat_debounce.sv
// Bench for seat_debounce: table vectors, hand-written corner sequences,
// a randomized run against a reference model, and a DEBOUNCE_CYCLES=1 / 8-seat instance.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_seat_debounce;

    localparam int N  = 5;
    localparam int DC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] seat, occ, vac;
    logic         chg;
    logic [2:0]   cnt;

    seat_debounce #(.N_SEATS(N), .DEBOUNCE_CYCLES(DC)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_seat_raw(raw),
        .o_seat(seat), .o_occupy(occ), .o_vacate(vac),
        .o_change(chg), .o_count(cnt)
    );

    logic       rst8;
    logic [7:0] raw8, seat8, occ8, vac8;
    logic       chg8;
    logic [3:0] cnt8;

    seat_debounce #(.N_SEATS(8), .DEBOUNCE_CYCLES(1)) u_dut8 (
        .i_clk(clk), .i_rst(rst8), .i_seat_raw(raw8),
        .o_seat(seat8), .o_occupy(occ8), .o_vacate(vac8),
        .o_change(chg8), .o_count(cnt8)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a seat adopts the synchronised level once the last DC
    // samples taken since its previous change (or reset) all disagree with it.
    logic [N-1:0] m_sync1, m_s, m_seat, m_occ, m_vac;
    logic         m_chg;
    logic [N-1:0] s_hist[$];
    int           since[N];

    task automatic model_reset();
        m_sync1 = '0; m_s = '0; m_seat = '0; m_occ = '0; m_vac = '0; m_chg = 1'b0;
        s_hist.delete();
        for (int k = 0; k < N; k++) since[k] = 0;
    endtask

    task automatic model_edge(input logic r, input logic [N-1:0] r_raw);
        logic [N-1:0] v;
        bit all_dis;
        if (r) begin
            model_reset();
            return;
        end
        s_hist.push_back(m_s);
        if (s_hist.size() > 16) void'(s_hist.pop_front());
        m_occ = '0;
        m_vac = '0;
        for (int k = 0; k < N; k++) begin
            since[k]++;
            if (since[k] >= DC) begin
                all_dis = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    v = s_hist[s_hist.size() - 1 - j];
                    if (v[k] == m_seat[k]) all_dis = 1'b0;
                end
                if (all_dis) begin
                    m_seat[k] = ~m_seat[k];
                    if (m_seat[k]) m_occ[k] = 1'b1;
                    else           m_vac[k] = 1'b1;
                    since[k] = 0;
                end
            end
        end
        m_chg   = |(m_occ | m_vac);
        m_s     = m_sync1;
        m_sync1 = r_raw;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".seat"},  32'(seat), 32'(m_seat));
        chk({tag, ".occ"},   32'(occ),  32'(m_occ));
        chk({tag, ".vac"},   32'(vac),  32'(m_vac));
        chk({tag, ".chg"},   32'(chg),  32'(m_chg));
        chk({tag, ".count"}, 32'(cnt),  32'($countones(m_seat)));
    endtask

    task automatic step(input logic r, input logic [N-1:0] nraw, input string tag);
        @(negedge clk);
        rst = r;
        raw = nraw;
        @(posedge clk);
        model_edge(r, nraw);
        #1;
        compare_model(tag);
    endtask

    // Async reset asserted mid-cycle: outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk({tag, ".async_seat"},  32'(seat), 32'd0);
        chk({tag, ".async_occ"},   32'(occ),  32'd0);
        chk({tag, ".async_count"}, 32'(cnt),  32'd0);
        @(posedge clk);
        model_edge(1'b1, raw);
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        logic         r;
        logic [N-1:0] rw;
        logic [N-1:0] seat;
        logic [N-1:0] occ;
        logic [N-1:0] vac;
        logic         chg;
        logic [2:0]   count;
    } vec_t;

    function automatic vec_t v(input logic r, input logic [N-1:0] rw, input logic [N-1:0] s,
                               input logic [N-1:0] o, input logic [N-1:0] va,
                               input logic c, input logic [2:0] n);
        vec_t x;
        x.r = r; x.rw = rw; x.seat = s; x.occ = o; x.vac = va; x.chg = c; x.count = n;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, pulses, chg_cnt;
        logic [N-1:0] nr;
        logic r;

        // Reset with all seats held, release, full latency; then seat 2 on and off.
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 5'h1F, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 5'h1F, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 5'h1F, 5'h1F, 5'h1F, 0, 1, 5));
        tbl.push_back(v(0, 5'h1F, 5'h1F, 0, 0, 0, 5));
        tbl.push_back(v(1, 5'h00, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 5'h04, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 5'h04, 5'h04, 5'h04, 0, 1, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(v(0, 5'h04, 5'h04, 0, 0, 0, 1));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 5'h00, 5'h04, 0, 0, 0, 1));
        tbl.push_back(v(0, 5'h00, 0, 0, 5'h04, 1, 0));
        tbl.push_back(v(0, 5'h00, 0, 0, 0, 0, 0));

        rst  = 1'b1;
        raw  = '0;
        rst8 = 1'b1;
        raw8 = '0;
        model_reset();
        #1;
        chk("reset.seat",  32'(seat), 32'd0);
        chk("reset.count", 32'(cnt),  32'd0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].rw, "table_model");
            chk($sformatf("table[%0d].seat", i),  32'(seat), 32'(tbl[i].seat));
            chk($sformatf("table[%0d].occ", i),   32'(occ),  32'(tbl[i].occ));
            chk($sformatf("table[%0d].vac", i),   32'(vac),  32'(tbl[i].vac));
            chk($sformatf("table[%0d].chg", i),   32'(chg),  32'(tbl[i].chg));
            chk($sformatf("table[%0d].count", i), 32'(cnt),  32'(tbl[i].count));
        end

        // Bounce on seat 0 with 3-sample high phases: must be rejected.
        pulses = 0;
        foreach (tbl[i]) begin end
        begin
            logic [7:0] pat;
            pat = 8'b0111_0111;
            for (int i = 0; i < 8; i++) begin
                step(1'b0, {4'b0, pat[i]}, "bounce");
                pulses += $countones(occ) + $countones(vac);
            end
            for (int i = 0; i < 8; i++) begin
                step(1'b0, 5'h00, "bounce_hold0");
                pulses += $countones(occ) + $countones(vac);
            end
        end
        chk("bounce.pulses", 32'(pulses), 32'd0);
        chk("bounce.seat0",  32'(seat[0]), 32'd0);
        first = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 5'h01, "accept");
            if (occ[0] && first < 0) first = i;
        end
        chk("accept.latency", 32'(first), 32'd5);
        chk("accept.seat",    32'(seat),  32'h01);

        // Simultaneous opposite-direction events from 00011 to 11100.
        for (int i = 0; i < 8; i++) step(1'b0, 5'h03, "simul_setup");
        chk("simul.before_count", 32'(cnt), 32'd2);
        chg_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 5'h1C, "simul");
            chg_cnt += int'(chg);
            if (i == 4) chk("simul.e4_seat", 32'(seat), 32'h03);
            if (i == 5) begin
                chk("simul.seat",  32'(seat), 32'h1C);
                chk("simul.occ",   32'(occ),  32'h1C);
                chk("simul.vac",   32'(vac),  32'h03);
                chk("simul.chg",   32'(chg),  32'd1);
                chk("simul.count", 32'(cnt),  32'd3);
            end
        end
        chk("simul.chg_cycles", 32'(chg_cnt), 32'd1);

        // Reset mid-debounce on seat 4: pending count discarded, full latency again.
        async_reset("midrst_clear");
        for (int i = 0; i < 3; i++) step(1'b0, 5'h10, "midrst_pre");
        async_reset("midrst_e3");
        first  = -1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 5'h10, "midrst_post");
            pulses += $countones(occ);
            if (occ[4] && first < 0) first = i;
        end
        chk("midrst.latency", 32'(first),  32'd5);
        chk("midrst.pulses",  32'(pulses), 32'd1);
        chk("midrst.count",   32'(cnt),    32'd1);

        // Randomized run against the model, with occasional resets and quiet spells.
        nr = 5'h10;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) nr = nr ^ 5'($urandom_range(0, 31));
            r = ($urandom_range(0, 99) == 0);
            step(r, nr, "random");
        end

        // DEBOUNCE_CYCLES=1, 8 seats: two-edge latency and a 4-bit count reaching 8.
        @(negedge clk);
        rst8 = 1'b0;
        raw8 = 8'hFF;
        @(posedge clk); #1;
        chk("sweep.e0_seat", 32'(seat8), 32'h00);
        @(posedge clk); #1;
        chk("sweep.e1_seat", 32'(seat8), 32'h00);
        @(posedge clk); #1;
        chk("sweep.e2_seat",  32'(seat8), 32'hFF);
        chk("sweep.e2_occ",   32'(occ8),  32'hFF);
        chk("sweep.e2_chg",   32'(chg8),  32'd1);
        chk("sweep.e2_count", 32'(cnt8),  32'd8);
        @(negedge clk);
        raw8 = 8'h0F;
        @(posedge clk); #1;
        chk("sweep.f0_seat", 32'(seat8), 32'hFF);
        chk("sweep.f0_chg",  32'(chg8),  32'd0);
        @(posedge clk); #1;
        chk("sweep.f1_seat", 32'(seat8), 32'hFF);
        @(posedge clk); #1;
        chk("sweep.f2_seat",  32'(seat8), 32'h0F);
        chk("sweep.f2_vac",   32'(vac8),  32'hF0);
        chk("sweep.f2_occ",   32'(occ8),  32'h00);
        chk("sweep.f2_count", 32'(cnt8),  32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
